// File: rtl/des_pkg.sv
// des_pkg: shared types and constants for the DES round controller, key schedule and datapath.
package des_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, ROUND, DONE} des_state_t;
    localparam int DES_ROUNDS = 16;
    // bit r-1 set => round r rotates the key halves by one position
    localparam logic [15:0] SHIFT_ONE_MASK = 16'b1000_0001_0000_0011;
endpackage

// File: rtl/des_shift_sched.sv
// des_shift_sched: per-round C/D rotation amount from round number and mode.
module des_shift_sched
    import des_pkg::*;
#(
    parameter int RND_W = 5
) (
    input  logic             en,
    input  logic             dec,
    input  logic [RND_W-1:0] round_num,
    output logic [1:0]       key_shamt
);
    logic [RND_W-1:0] idx;
    logic             one;
    // decrypt skips the first rotation so the right-rotation total lands back on K16
    always_comb begin
        idx       = round_num - RND_W'(1);
        one       = SHIFT_ONE_MASK[idx[3:0]];
        key_shamt = !en ? 2'd0 : (dec && round_num == RND_W'(1)) ? 2'd0 : one ? 2'd1 : 2'd2;
    end
endmodule

// File: rtl/des_round_ctrl.sv
// des_round_ctrl: IDLE/LOAD/ROUND/DONE sequencer for the iterative DES core.
module des_round_ctrl
    import des_pkg::*;
#(
    parameter int NUM_ROUNDS = DES_ROUNDS,
    parameter int RND_W      = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             mode_dec,
    input  logic             flush,
    output logic             ld_data,
    output logic             ld_key,
    output logic             round_en,
    output logic [1:0]       key_shamt,
    output logic             key_dir,
    output logic [RND_W-1:0] round_num,
    output logic             last_round,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);
    des_state_t       state, state_nxt;
    logic [RND_W-1:0] rnd_q;
    logic             mode_q;
    logic             accept;

    // rst_n gates the load strobes so nothing is captured while reset is held
    assign accept = in_valid && in_ready && !flush && rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            rnd_q  <= '0;
            mode_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            rnd_q  <= (state_nxt == ROUND) ? ((state == ROUND) ? rnd_q + RND_W'(1) : RND_W'(1)) : '0;
            mode_q <= accept ? mode_dec : mode_q;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = accept ? LOAD : IDLE;
            LOAD:    state_nxt = ROUND;
            ROUND:   state_nxt = (rnd_q == RND_W'(NUM_ROUNDS)) ? DONE : ROUND;
            DONE:    state_nxt = out_ready ? IDLE : DONE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    always_comb begin
        in_ready   = state == IDLE;
        busy       = state != IDLE;
        out_valid  = state == DONE;
        round_en   = state == ROUND;
        last_round = round_en && rnd_q == RND_W'(NUM_ROUNDS);
        round_num  = rnd_q;
        key_dir    = mode_q;
        ld_data    = accept;
        ld_key     = accept;
    end

    des_shift_sched #(.RND_W(RND_W)) u_sched (
        .en       (round_en),
        .dec      (mode_q),
        .round_num(rnd_q),
        .key_shamt(key_shamt)
    );
endmodule
